// File: rtl/cpu86_icache_dispatch_if.sv
// Bus bundle for the icache dispatcher: fetch-address/tag join inputs,
// per-port lookup request outputs and per-port response credit strobes.
interface cpu86_icache_dispatch_if #(
    parameter int S_QTY       = 4,
    parameter int ADDR_WIDTH  = 20,
    parameter int TUSER_WIDTH = 4
);
    logic                           s_axis_req_tvalid;
    logic                           s_axis_req_tready;
    logic [ADDR_WIDTH-1:0]          s_axis_req_tdata;
    logic                           s_axis_tag_tvalid;
    logic                           s_axis_tag_tready;
    logic [TUSER_WIDTH-1:0]         s_axis_tag_tdata;
    logic [S_QTY-1:0]               m_axis_port_tvalid;
    logic [S_QTY-1:0]               m_axis_port_tready;
    logic [S_QTY*ADDR_WIDTH-1:0]    m_axis_port_tdata;
    logic [S_QTY*TUSER_WIDTH-1:0]   m_axis_port_tuser;
    logic [S_QTY-1:0]               s_axis_resp_tvalid;

    // master: the dispatcher itself; slave: prefetcher, ROB and lookup ports around it
    modport master (
        input  s_axis_req_tvalid, s_axis_req_tdata,
        input  s_axis_tag_tvalid, s_axis_tag_tdata,
        input  m_axis_port_tready, s_axis_resp_tvalid,
        output s_axis_req_tready, s_axis_tag_tready,
        output m_axis_port_tvalid, m_axis_port_tdata, m_axis_port_tuser
    );

    modport slave (
        output s_axis_req_tvalid, s_axis_req_tdata,
        output s_axis_tag_tvalid, s_axis_tag_tdata,
        output m_axis_port_tready, s_axis_resp_tvalid,
        input  s_axis_req_tready, s_axis_tag_tready,
        input  m_axis_port_tvalid, m_axis_port_tdata, m_axis_port_tuser
    );
endinterface

// File: rtl/cpu86_icache_dispatch.sv
// Joins fetch addresses with ROB tags and dispatches each pair to a lookup
// port chosen round-robin among ports that still have outstanding credit.
module cpu86_icache_dispatch #(
    parameter int S_QTY           = 4,
    parameter int ADDR_WIDTH      = 20,
    parameter int TUSER_WIDTH     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu86_icache_dispatch_if.master bus,
    output logic                    busy,
    output logic                    err_underflow
);
    localparam int SEL_W = (S_QTY > 1) ? $clog2(S_QTY) : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [SEL_W-1:0]     LAST_PORT = SEL_W'(S_QTY - 1);

    logic                   hold_valid_reg;
    logic                   hold_valid_next;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [TUSER_WIDTH-1:0] tag_reg;
    logic [SEL_W-1:0]       sel_reg;
    logic [SEL_W-1:0]       sel_next;
    logic [SEL_W-1:0]       rr_ptr_reg;
    logic [SEL_W-1:0]       rr_ptr_next;
    logic                   err_underflow_reg;

    logic [S_QTY-1:0]       avail;
    logic [S_QTY-1:0]       cnt_nz;
    logic [S_QTY-1:0]       underflow;
    logic                   any_avail;
    logic                   accept;
    logic                   load_en;
    logic                   load;

    // Rotating first-fit search starting at rr_ptr; sum stays below 2*S_QTY.
    always_comb begin : rr_search
        logic             found;
        logic [SEL_W:0]   sum;
        sel_next = '0;
        found    = 1'b0;
        sum      = '0;
        for (int k = 0; k < S_QTY; k++) begin
            sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(S_QTY)) begin
                sum = sum - (SEL_W+1)'(S_QTY);
            end
            if (!found && avail[sum[SEL_W-1:0]]) begin
                sel_next = sum[SEL_W-1:0];
                found    = 1'b1;
            end
        end
    end

    assign rr_ptr_next = (sel_next == LAST_PORT) ? '0 : sel_next + SEL_W'(1);
    assign any_avail   = |avail;
    assign accept      = hold_valid_reg & bus.m_axis_port_tready[sel_reg];
    assign load_en     = (~hold_valid_reg | accept) & any_avail;

    // Both streams are consumed together or not at all.
    assign bus.s_axis_req_tready = load_en & bus.s_axis_tag_tvalid;
    assign bus.s_axis_tag_tready = load_en & bus.s_axis_req_tvalid;
    assign load = load_en & bus.s_axis_req_tvalid & bus.s_axis_tag_tvalid;

    always_comb begin
        hold_valid_next = hold_valid_reg;
        if (load) begin
            hold_valid_next = 1'b1;
        end else if (accept) begin
            hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_reg    <= 1'b0;
            rr_ptr_reg        <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            if (load) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (|underflow) begin
                err_underflow_reg <= 1'b1;
            end
        end
    end

    // Payload registers need no reset: they are only observed while hold_valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            addr_reg <= bus.s_axis_req_tdata;
            tag_reg  <= bus.s_axis_tag_tdata;
            sel_reg  <= sel_next;
        end
    end

    // Per-port credit counters: reserved at load, returned by the response strobe.
    generate
        for (genvar gi = 0; gi < S_QTY; gi++) begin : g_port
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 inc;
            logic                 dec;

            assign inc           = load && (sel_next == SEL_W'(gi));
            assign dec           = bus.s_axis_resp_tvalid[gi];
            assign underflow[gi] = dec && !inc && (cnt_reg == '0);
            assign avail[gi]     = (cnt_reg < MAX_CNT);
            assign cnt_nz[gi]    = |cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc && !dec) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end else if (dec && !inc && (cnt_reg != '0)) begin
                    cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                end
            end

            assign bus.m_axis_port_tvalid[gi] = hold_valid_reg && (sel_reg == SEL_W'(gi));
            assign bus.m_axis_port_tdata[gi*ADDR_WIDTH +: ADDR_WIDTH]   = addr_reg;
            assign bus.m_axis_port_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH] = tag_reg;
        end
    endgenerate

    assign busy          = hold_valid_reg | (|cnt_nz);
    assign err_underflow = err_underflow_reg;

endmodule

// File: doc/cpu86_icache_dispatch.md
Name: cpu86_icache_dispatch

Overview:
Front-end scheduler for the icache reorder buffer. Pairs each fetch address from the prefetcher with a reorder tag issued by the ROB, then dispatches the address/tag pair to one of S_QTY cache lookup ports. Port choice is round-robin, gated by per-port outstanding-credit counters. The same per-port response valids that update the ROB also return credits here.

Parameters:
S_QTY, 4, number of lookup ports (≥2)
ADDR_WIDTH, 20, fetch address width
TUSER_WIDTH, 4, ROB tag width
MAX_OUTSTANDING, 4, max in-flight requests per port (1..2**CNT_WIDTH-1)
CNT_WIDTH, 3, width of each credit counter

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
s_axis_req_tvalid  in  1  fetch address valid
s_axis_req_tready  out  1  fetch address accepted
s_axis_req_tdata  in  ADDR_WIDTH  fetch address
s_axis_tag_tvalid  in  1  ROB tag valid (from ROB m_axis_tag)
s_axis_tag_tready  out  1  ROB tag consumed
s_axis_tag_tdata  in  TUSER_WIDTH  ROB tag
m_axis_port_tvalid  out  S_QTY  per-port request valid, at most one bit set
m_axis_port_tready  in  S_QTY  per-port request ready
m_axis_port_tdata  out  S_QTY*ADDR_WIDTH  address, same value replicated to every lane
m_axis_port_tuser  out  S_QTY*TUSER_WIDTH  tag, same value replicated to every lane
s_axis_resp_tvalid  in  S_QTY  per-port response strobe, returns one credit
busy  out  1  hold register valid, or any credit counter nonzero
err_underflow  out  1  sticky flag: response seen on a port with zero outstanding

Behaviour:
- Reset (async, active-high): hold_valid=0, all m_axis_port_tvalid=0, rr_ptr=0, all cnt=0, err_underflow=0, busy=0. Output data regs are don't-care. Reset asserted mid-transfer drops tvalid immediately, with no wait for a clock edge.
- Hold stage: one register holds {addr, tag, sel}; hold_valid marks it full.
- accept = hold_valid & m_axis_port_tready[sel].
- Port eligibility: avail[i] = (cnt[i] < MAX_OUTSTANDING), from registered counts only.
- sel_next = first i with avail[i], searching rr_ptr, rr_ptr+1, ... modulo S_QTY.
- any_avail = OR of avail.
- load_en = (~hold_valid | accept) & any_avail.
- Join: s_axis_req_tready = load_en & s_axis_tag_tvalid. s_axis_tag_tready = load_en & s_axis_req_tvalid.
- Join rule: neither stream is consumed without the other. A load occurs when both are valid and load_en=1.
- On load: capture addr, tag and sel<=sel_next; hold_valid<=1; rr_ptr<=(sel_next+1) mod S_QTY; cnt[sel_next] increments. The credit is reserved at load, not at accept.
- On accept with no load: hold_valid<=0.
- Latency: pair accepted at edge N; m_axis_port_tvalid[sel] high after edge N. Sustained throughput is 1 per cycle while the selected port is ready and credits remain.
- Output signals: m_axis_port_tvalid = hold_valid ? onehot(sel) : 0.
- AXI stability: while tvalid is high and tready is low, tvalid, sel, tdata and tuser hold constant.
- Credit return: s_axis_resp_tvalid[i]=1 decrements cnt[i].
  - Load to i and response on i in the same cycle: cnt[i] unchanged.
  - Response on i with cnt[i]=0 and no same-cycle load to i: cnt[i] stays 0 and err_underflow<=1. The flag is cleared only by reset.
- All ports at MAX_OUTSTANDING: any_avail=0, both treadys low. The hold register still drains independently.
- ROB full: the ROB holds tag tvalid low, so the dispatcher stalls with no loss. Addresses are not consumed.
- rr_ptr wraps from S_QTY-1 to 0. The counter never wraps, guaranteed by MAX_OUTSTANDING ≤ 2**CNT_WIDTH-1.
- busy is combinational from registered state.

Test Plan:
1. Idle, all ready. Send addr 0x12345 with tag 3 → one cycle later m_axis_port_tvalid=4'b0001, lane0 tdata=0x12345, tuser=3; cnt[0]=1; busy=1.
2. Send four pairs back-to-back, tags 0..3, all ports ready → tvalid sequence 0001, 0010, 0100, 1000 on consecutive cycles; rr_ptr returns to 0.
3. Preload cnt[1]=4 with no responses, then send two requests → dispatched to port0 then port2; port1 is skipped.
4. All cnt=4 → req/tag tready stay 0 for 5 cycles. Pulse s_axis_resp_tvalid=4'b0100 → the next pair loads to port2, and cnt[2] returns to 4.
5. Hold m_axis_port_tready[0]=0 for 3 cycles with a request pending on port0 → tvalid, tdata and tuser stay stable and no new pair is accepted. On ready, the next pair is dispatched the following cycle.
6. Response on port3 with cnt[3]=0 → err_underflow=1 and cnt[3]=0. Then assert reset mid-transfer → tvalid=0 without a clock edge, and err_underflow=0.
